cache_arbiter: RTL

- Shares the single physical-memory line port between the I-cache (fetch-side misses) and the D-cache (MEM-stage misses and writebacks) of the 5-stage rv32i pipeline.
- Grants one requester at a time and holds the grant until memory responds.
- Latches the granted request, drives pmem, and routes the response back to the owner only.

---
 rtl/rv32i_types.sv | 16 +
 rtl/arbiter_grant_sel.sv | 17 +
 rtl/cache_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared type definitions for the rv32i pipeline memory side.
// Holds the cache arbiter state and owner encodings.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arbiter_grant_sel.sv
// Grant selection for the cache arbiter.
// On a tie the requester that did not own memory last wins. A fixed
// D-cache priority is this same rule with last_owner held at OWNER_I.
module arbiter_grant_sel
  import rv32i_types::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_owner_t last_owner,
  output logic       grant_i,
  output logic       grant_d
);

  assign grant_d = d_req & (~i_req | (last_owner == OWNER_I));
  assign grant_i = i_req & (~d_req | (last_owner == OWNER_D));

endmodule

// File: rtl/cache_arbiter.sv
// Shares the physical-memory line port between the I-cache and D-cache.
// One owner at a time; the request is latched at grant and held until
// pmem_resp. Optional macro ARB_ROUND_ROBIN_EN adds a last_owner register
// so simultaneous requests alternate instead of always favouring D.
//
// state   | meaning
// IDLE    | no grant, sample requests
// GRANT_I | I-cache owns pmem
// GRANT_D | D-cache owns pmem
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  arb_owner_t        last_owner;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              op_write_q;
  logic              d_req;
  logic              grant_i;
  logic              grant_d;
  logic              busy;

  assign d_req = d_read | d_write;

  arbiter_grant_sel u_grant_sel (
    .i_req      (i_read),
    .d_req      (d_req),
    .last_owner (last_owner),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who was granted last so the next tie goes the other way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWNER_I;
    end else if (state == IDLE) begin
      if (grant_d) begin
        last_owner <= OWNER_D;
      end else if (grant_i) begin
        last_owner <= OWNER_I;
      end
    end
  end
`else
  assign last_owner = OWNER_I;
`endif

  // Next-state: grant from IDLE, return to IDLE on memory completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = GRANT_D;
        end else if (grant_i) begin
          state_nxt = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (pmem_resp) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the winning request on the grant edge; later requester changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_d) begin
        addr_q     <= d_addr;
        op_write_q <= d_write;
        if (d_write) begin
          wdata_q <= d_wdata;
        end
      end else if (grant_i) begin
        addr_q     <= i_addr;
        op_write_q <= 1'b0;
      end
    end
  end

  assign busy       = (state == GRANT_I) || (state == GRANT_D);
  assign pmem_read  = busy & ~op_write_q;
  assign pmem_write = busy & op_write_q;
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;

  // Completion goes to the owner only; rdata is a plain passthrough.
  assign i_resp  = (state == GRANT_I) & pmem_resp;
  assign d_resp  = (state == GRANT_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule
